// File: rtl/btn_debounce_pulse.sv
// rtl/btn_debounce_pulse.sv - per-channel synchroniser, debounce FSM and registered rise/fall pulses
// Optional hold-to-repeat on db_rise when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce_pulse #(
  parameter int N_CH        = 4,
  parameter int DB_CYCLES   = 1000000,
  parameter int CNT_W       = 20,
  parameter int HOLD_CYCLES = 50000000,
  parameter int RPT_CYCLES  = 10000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] db_rise,
  output logic [N_CH-1:0] db_fall
);

  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || (DB_CYCLES >> CNT_W) != 0 || HOLD_CYCLES < 1 || RPT_CYCLES < 1) begin : g_bad_cfg
    $error("btn_debounce_pulse: invalid DB_CYCLES/CNT_W/HOLD_CYCLES/RPT_CYCLES");
  end

  logic [N_CH-1:0] s1, s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_q, rise_q, fall_q;
    logic             level_nxt, rise_nxt, fall_nxt;
`ifdef BTN_AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(HOLD_CYCLES + RPT_CYCLES + 1);
    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt;
    logic             rpt_phase, rpt_phase_nxt;
`endif

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state   <= IDLE_LOW;
        cnt     <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
`endif
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        level_q <= level_nxt;
        rise_q  <= rise_nxt;
        fall_q  <= fall_nxt;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_cnt   <= rpt_cnt_nxt;
        rpt_phase <= rpt_phase_nxt;
`endif
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = level_q;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
        IDLE_LOW: begin
          if (s2[i]) begin
            state_nxt = WAIT_HIGH;
            cnt_nxt   = CNT_W'(1);
          end else begin
            cnt_nxt = '0;
          end
        end
        WAIT_HIGH: begin
          if (!s2[i]) begin
            state_nxt = IDLE_LOW;
            cnt_nxt   = '0;
          end else if (cnt == DB_LAST) begin
            state_nxt = IDLE_HIGH;
            level_nxt = 1'b1;
            rise_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        IDLE_HIGH: begin
          if (!s2[i]) begin
            state_nxt = WAIT_LOW;
            cnt_nxt   = CNT_W'(1);
          end else begin
            cnt_nxt = '0;
          end
        end
        WAIT_LOW: begin
          if (s2[i]) begin
            state_nxt = IDLE_HIGH;
            cnt_nxt   = '0;
          end else if (cnt == DB_LAST) begin
            state_nxt = IDLE_LOW;
            level_nxt = 1'b0;
            fall_nxt  = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end
      endcase
`ifdef BTN_AUTO_REPEAT_EN
      // First repeat waits HOLD_CYCLES, later ones RPT_CYCLES; any exit from IDLE_HIGH rearms.
      rpt_cnt_nxt   = '0;
      rpt_phase_nxt = 1'b0;
      if (state == IDLE_HIGH && s2[i]) begin
        rpt_phase_nxt = rpt_phase;
        if (rpt_cnt == (rpt_phase ? RPT_W'(RPT_CYCLES - 1) : RPT_W'(HOLD_CYCLES - 1))) begin
          rise_nxt      = 1'b1;
          rpt_phase_nxt = 1'b1;
        end else begin
          rpt_cnt_nxt = rpt_cnt + RPT_W'(1);
        end
      end
`endif
    end

    assign db_level[i] = level_q;
    assign db_rise[i]  = rise_q;
    assign db_fall[i]  = fall_q;
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// tb/tb_btn_debounce_pulse.sv - vector table, corner sequences and random run against a run-length model
module tb_btn_debounce_pulse;

  localparam int N    = 4;
  localparam int DB   = 8;
  localparam int HOLD = 40;
  localparam int RPT  = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] db_level, db_rise, db_fall;

  btn_debounce_pulse #(
    .N_CH(N), .DB_CYCLES(DB), .CNT_W(4), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .db_level(db_level), .db_rise(db_rise), .db_fall(db_fall)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a level flips once DB consecutive synchronised samples disagree with it.
  logic [N-1:0] pipe[$];
  logic [N-1:0] m_level, m_rise, m_fall;
  int           run[N];
`ifdef BTN_AUTO_REPEAT_EN
  logic [N-1:0] m_prev;
  int           hc[N];
`endif

  typedef struct {
    logic [N-1:0] btn;
    int           n;
    logic [N-1:0] lvl;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } vec_t;
  vec_t vecs[$];

  function automatic void model_reset();
    pipe = {};
    pipe.push_back('0);
    pipe.push_back('0);
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    for (int c = 0; c < N; c++) run[c] = 0;
`ifdef BTN_AUTO_REPEAT_EN
    m_prev = '0;
    for (int c = 0; c < N; c++) hc[c] = 0;
`endif
  endfunction

  function automatic void model_step(logic [N-1:0] b);
    logic [N-1:0] v;
    v = pipe.pop_front();
    pipe.push_back(b);
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < N; c++) begin
`ifdef BTN_AUTO_REPEAT_EN
      if (m_level[c] && v[c] && m_prev[c]) begin
        hc[c]++;
        if (hc[c] == HOLD || (hc[c] > HOLD && (hc[c] - HOLD) % RPT == 0)) m_rise[c] = 1'b1;
      end else begin
        hc[c] = 0;
      end
`endif
      if (v[c] != m_level[c]) begin
        run[c]++;
        if (run[c] == DB) begin
          m_level[c] = v[c];
          m_rise[c]  = v[c];
          m_fall[c]  = ~v[c];
          run[c]     = 0;
        end
      end else begin
        run[c] = 0;
      end
    end
`ifdef BTN_AUTO_REPEAT_EN
    m_prev = v;
`endif
  endfunction

  task automatic check(string name, logic [N-1:0] act, logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step(btn_in);
    @(negedge clk);
    check("model level", db_level, m_level);
    check("model rise", db_rise, m_rise);
    check("model fall", db_fall, m_fall);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    check("reset level", db_level, '0);
    check("reset rise", db_rise, '0);
    check("reset fall", db_fall, '0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic void add(logic [N-1:0] b, int n, logic [N-1:0] l, logic [N-1:0] r, logic [N-1:0] f);
    vec_t v;
    v.btn = b; v.n = n; v.lvl = l; v.rise = r; v.fall = f;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [N-1:0] b;
    int pulses, exp_pulses;

    // clean press / release on ch0
    add(4'b0001, 9, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 1, 4'b0001, 4'b0001, 4'b0000);
    add(4'b0001, 1, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0001, 20, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 9, 4'b0001, 4'b0000, 4'b0000);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
    // bounce on ch1, then settle high and release
    add(4'b0010, 3, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 3, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0010, 3, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 3, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0010, 9, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0010, 1, 4'b0010, 4'b0010, 4'b0000);
    add(4'b0010, 1, 4'b0010, 4'b0000, 4'b0000);
    add(4'b0000, 10, 4'b0000, 4'b0000, 4'b0010);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
    // one-cycle glitch during WAIT_HIGH restarts the count
    add(4'b0001, 6, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 9, 4'b0000, 4'b0000, 4'b0000);
    add(4'b0001, 1, 4'b0001, 4'b0001, 4'b0000);
    add(4'b0000, 10, 4'b0000, 4'b0000, 4'b0001);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
    // ch2 press and release
    add(4'b0100, 10, 4'b0100, 4'b0100, 4'b0000);
    add(4'b0100, 1, 4'b0100, 4'b0000, 4'b0000);
    add(4'b0000, 10, 4'b0000, 4'b0000, 4'b0100);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);
    // all channels together
    add(4'b1111, 10, 4'b1111, 4'b1111, 4'b0000);
    add(4'b1111, 1, 4'b1111, 4'b0000, 4'b0000);
    add(4'b0000, 10, 4'b0000, 4'b0000, 4'b1111);
    add(4'b0000, 1, 4'b0000, 4'b0000, 4'b0000);

    model_reset();
    repeat (3) @(negedge clk);
    check("initial reset level", db_level, '0);
    check("initial reset rise", db_rise, '0);
    check("initial reset fall", db_fall, '0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      btn_in = vecs[i].btn;
      repeat (vecs[i].n) tick();
      check($sformatf("vec%0d level", i), db_level, vecs[i].lvl);
      check($sformatf("vec%0d rise", i), db_rise, vecs[i].rise);
      check($sformatf("vec%0d fall", i), db_fall, vecs[i].fall);
    end

    // reset mid-count: ch2 already high, ch3 counting; both held through release
    btn_in = 4'b0100;
    repeat (10) tick();
    check("pre-reset level", db_level, 4'b0100);
    btn_in = 4'b1100;
    repeat (5) tick();
    do_reset();
    repeat (9) tick();
    check("post-reset early level", db_level, 4'b0000);
    check("post-reset early rise", db_rise, 4'b0000);
    tick();
    check("post-reset level", db_level, 4'b1100);
    check("post-reset rise", db_rise, 4'b1100);
    tick();
    check("post-reset rise end", db_rise, 4'b0000);
    btn_in = '0;
    repeat (12) tick();

    // long hold on ch0: one pulse, or accept + repeats
    btn_in = 4'b0001;
    pulses = 0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (db_rise[0]) pulses++;
    end
`ifdef BTN_AUTO_REPEAT_EN
    exp_pulses = 7;
`else
    exp_pulses = 1;
`endif
    check("hold pulse count", N'(pulses), N'(exp_pulses));
    btn_in = '0;
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (db_rise[0]) pulses++;
    end
    check("after release pulses", N'(pulses), '0);
    check("after release level", db_level, '0);

    // random toggling with occasional asynchronous reset
    for (int t = 0; t < 2500; t++) begin
      b = btn_in;
      for (int c = 0; c < N; c++) if ($urandom_range(11) == 0) b[c] = ~b[c];
      btn_in = b;
      if ($urandom_range(799) == 0) do_reset();
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
- Multi-channel push-button/switch conditioner upstream of up_down_modcnter.
- Synchronises raw board inputs to clk and debounces each channel with a stability counter.
- Emits a clean level plus single-cycle rise/fall pulses, so load, Ud and En reach the counter glitch-free and a press registers exactly once.

Parameters:
- N_CH, 4, number of independent input channels.
- DB_CYCLES, 1000000, consecutive stable clk cycles required to accept a new level (10 ms at 100 MHz); must be >= 2.
- CNT_W, 20, stability counter width; must satisfy 2^CNT_W > DB_CYCLES.
- HOLD_CYCLES, 50000000, auto-repeat initial delay (used only with AUTO_REPEAT_EN).
- RPT_CYCLES, 10000000, auto-repeat period (used only with AUTO_REPEAT_EN).

Ports:
- clk, input, 1, system clock, 100 MHz board clock.
- rst, input, 1, asynchronous active-low reset; 0 resets all state immediately.
- btn_in, input, N_CH, raw asynchronous button/switch inputs.
- db_level, output, N_CH, debounced level per channel.
- db_rise, output, N_CH, one-cycle pulse on accepted 0->1 (plus repeats when AUTO_REPEAT_EN).
- db_fall, output, N_CH, one-cycle pulse on accepted 1->0.

Behaviour:
- Reset (rst=0, async): sync flops=0, every channel state=IDLE_LOW, counters=0, db_level=0, db_rise=0, db_fall=0. Release is taken on the next clk rising edge.
- Synchroniser: two-flop chain per channel (s1, s2); all decisions use s2 only.
- Per-channel FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - IDLE_LOW: s2=1 -> WAIT_HIGH, counter=1; otherwise counter held at 0.
  - WAIT_HIGH: s2=0 -> IDLE_LOW, counter=0 (bounce rejected, no output change).
  - WAIT_HIGH: s2=1 and counter==DB_CYCLES-1 -> IDLE_HIGH, db_level<=1, db_rise<=1 for one cycle, counter=0.
  - WAIT_HIGH: otherwise counter++.
  - IDLE_HIGH and WAIT_LOW: mirror images, producing db_level<=0 and a db_fall pulse.
- Latency: for a clean edge first sampled by s1 at edge k, db_level and the pulse update at edge k+DB_CYCLES+1, i.e. DB_CYCLES+2 edges counting edge k.
- Any bounce shorter than DB_CYCLES s2-cycles produces no output activity. A glitch during WAIT restarts the full count from 0.
- db_rise and db_fall are never both high on one channel in the same cycle. They are registered outputs and are never combinational from btn_in.
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.
- Counter saturates logically at DB_CYCLES-1 and never wraps.
- Input held at 1 through reset release: rise pulse after DB_CYCLES+2 cycles, treated as a new press.
- Reset asserted mid-WAIT: count is discarded, no pulse is emitted, and the channel returns to IDLE_LOW.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: per-channel repeat counter active in IDLE_HIGH.
  - After HOLD_CYCLES continuous cycles in IDLE_HIGH, db_rise pulses once.
  - It then pulses again every RPT_CYCLES while the channel stays in IDLE_HIGH.
  - Leaving IDLE_HIGH clears the repeat counter immediately.
  - db_level is unaffected by repeats.
- Undefined: no repeat logic is synthesised; db_rise fires only once per accepted press.

Test Plan (simulate with DB_CYCLES=8, HOLD_CYCLES=40, RPT_CYCLES=10):
- Clean press: btn_in[0] 0->1 held 30 cycles -> db_level[0]=1 exactly 10 edges after first sample; db_rise[0] high for exactly 1 cycle; other channels stay 0.
- Bounce: btn_in[1] toggles 1,0,1,0 every 3 cycles then settles to 1 -> no pulse during toggling; one db_rise[1] 10 edges after the final settle.
- Release: from db_level[2]=1, drive btn_in[2]=0 -> db_fall[2] one-cycle pulse 10 edges later; db_level[2]=0; db_rise[2] stays 0.
- Reset mid-count: btn_in[3]=1, pull rst=0 after 5 cycles for 2 cycles -> all outputs 0 immediately; db_rise[3] occurs 10 edges after release, not earlier.
- Simultaneous: btn_in=4'b1111 at one edge -> db_rise=4'b1111 in the same single cycle.
- BTN_AUTO_REPEAT_EN: hold btn_in[0] 100 cycles -> pulses at accept, accept+40, +50, +60, ...; release -> no further db_rise. Without the macro, the same stimulus gives exactly one pulse.
